// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target and its companion SPI master.
//   state_e           : target FSM states
//   SPI_MODE          : SPI mode used on the link (3: CPOL=1, CPHA=1)
//   SPI_SIZE_DEFAULT  : default frame length in bits
//   SCK_IDLE          : idle level of SCK implied by SPI_MODE
package spi_target_pkg;

    localparam int unsigned SPI_MODE         = 3;
    localparam int unsigned SPI_SIZE_DEFAULT = 40;
    localparam logic        SCK_IDLE         = (SPI_MODE >= 2);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_e;

endpackage

// File: rtl/spi_target_synchronizer.sv
// Multi-flop synchronizer for asynchronous single-bit inputs, bundled WIDTH wide.
//   clk_in      : destination clock
//   reset_n_in  : asynchronous active-low reset; every stage loads RESET_VAL
//   async_in    : asynchronous inputs
//   sync_out    : inputs after STAGES flops (STAGES >= 2)
module spi_target_synchronizer #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    // Stage 0 is the first flop after the pin, stage STAGES-1 feeds the logic.
    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI responder (mode 3, MSB first). Oversamples SCK/CS_n/MOSI on clk_in,
// captures one SIZE-bit word per chip-select window and shifts a reply word
// out on MISO in the same frame.
//   clk_in, reset_n_in : system clock (>= 8x SCK), async active-low reset
//   sck_in, cs_n_in,
//   mosi_in            : asynchronous SPI inputs
//   tx_data_in         : reply word, sampled at frame start
//   r_miso_out         : serial reply bit
//   r_miso_oe_out      : high while selected
//   r_rx_data_out      : last correctly sized received word
//   r_valid_out        : one-cycle pulse, r_rx_data_out updated
//   r_error_out        : one-cycle pulse, frame length != SIZE
//   r_busy_out         : high from frame start to frame end
module spi_target
    import spi_target_pkg::*;
#(
    parameter int unsigned SIZE        = SPI_SIZE_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk_in,
    input  logic            reset_n_in,
    input  logic            sck_in,
    input  logic            cs_n_in,
    input  logic            mosi_in,
    input  logic [SIZE-1:0] tx_data_in,
    output logic            r_miso_out,
    output logic            r_miso_oe_out,
    output logic [SIZE-1:0] r_rx_data_out,
    output logic            r_valid_out,
    output logic            r_error_out,
    output logic            r_busy_out
);

    localparam int unsigned CW = $clog2(SIZE + 2);

    logic [2:0] sync_out;
    logic       mosi_s, sck_s, cs_s;
    logic       sck_h_q, cs_h_q;
    logic       cs_fall, cs_rise, sck_rise, sck_fall;

    spi_target_synchronizer #(
        .WIDTH     (3),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL ({1'b0, SCK_IDLE, 1'b0})
    ) u_sync (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .async_in   ({mosi_in, sck_in, cs_n_in}),
        .sync_out   (sync_out)
    );

    assign {mosi_s, sck_s, cs_s} = sync_out;

    assign cs_fall  =  cs_h_q  & ~cs_s;
    assign cs_rise  = ~cs_h_q  &  cs_s;
    assign sck_rise = ~sck_h_q &  sck_s;
    assign sck_fall =  sck_h_q & ~sck_s;

    state_e          state_q, state_d;
    // The MSB of the reply goes straight to MISO at frame start, so the
    // shifter only holds the SIZE-1 bits still to be sent.
    logic [SIZE-2:0] tx_shift_q, tx_shift_d;
    logic [SIZE-1:0] rx_shift_q, rx_shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            miso_q, miso_d;
    logic            oe_q, oe_d;
    logic            busy_q, busy_d;
    logic [SIZE-1:0] rx_data_q, rx_data_d;
    logic            valid_q, valid_d;
    logic            error_q, error_d;

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        cnt_d      = cnt_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                if (cs_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    tx_shift_d = tx_data_in[SIZE-2:0];
                    rx_shift_d = '0;
                    cnt_d      = '0;
                    miso_d     = tx_data_in[SIZE-1];
                    oe_d       = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // CS release takes priority over an SCK edge in the same cycle.
                if (cs_rise) begin
                    state_d = DONE;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[SIZE-2:0], mosi_s};
                    if (cnt_q != CW'(SIZE + 1)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (sck_fall && (cnt_q != '0)) begin
                    // Leading falling edge (no bit sampled yet) keeps the MSB on MISO.
                    miso_d     = tx_shift_q[SIZE-2];
                    tx_shift_d = {tx_shift_q[SIZE-3:0], 1'b0};
                end
            end
            DONE: begin
                if (cnt_q == CW'(SIZE)) begin
                    rx_data_d = rx_shift_q;
                    valid_d   = 1'b1;
                end else begin
                    error_d   = 1'b1;
                end
                oe_d    = 1'b0;
                busy_d  = 1'b0;
                miso_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= WAIT_IDLE;
            sck_h_q    <= SCK_IDLE;
            cs_h_q     <= 1'b0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            cnt_q      <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sck_h_q    <= sck_s;
            cs_h_q     <= cs_s;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            cnt_q      <= cnt_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign r_miso_out    = miso_q;
    assign r_miso_oe_out = oe_q;
    assign r_rx_data_out = rx_data_q;
    assign r_valid_out   = valid_q;
    assign r_error_out   = error_q;
    assign r_busy_out    = busy_q;

endmodule

// File: tb/tb_spi_target.sv
`timescale 1ns/1ps
module tb_spi_target;

    localparam int SIZE = 40;
    localparam int SYNC = 2;

    logic            clk_in = 1'b0;
    logic            reset_n_in = 1'b0;
    logic            sck_in = 1'b1;
    logic            cs_n_in = 1'b1;
    logic            mosi_in = 1'b0;
    logic [SIZE-1:0] tx_data_in = '0;
    logic            r_miso_out;
    logic            r_miso_oe_out;
    logic [SIZE-1:0] r_rx_data_out;
    logic            r_valid_out;
    logic            r_error_out;
    logic            r_busy_out;

    spi_target #(
        .SIZE        (SIZE),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_in        (clk_in),
        .reset_n_in    (reset_n_in),
        .sck_in        (sck_in),
        .cs_n_in       (cs_n_in),
        .mosi_in       (mosi_in),
        .tx_data_in    (tx_data_in),
        .r_miso_out    (r_miso_out),
        .r_miso_oe_out (r_miso_oe_out),
        .r_rx_data_out (r_rx_data_out),
        .r_valid_out   (r_valid_out),
        .r_error_out   (r_error_out),
        .r_busy_out    (r_busy_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_mis = 0;

    // Pulse monitor, sampled away from the active edge.
    int              valid_cnt = 0;
    int              error_cnt = 0;
    logic [SIZE-1:0] rx_words[$];

    always @(negedge clk_in) begin
        if (r_valid_out) begin
            valid_cnt++;
            rx_words.push_back(r_rx_data_out);
        end
        if (r_error_out) error_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_in);
        #3;
    endtask

    task automatic check_quiet(input string name);
        check({name, " miso"}, 64'(r_miso_out), 64'd0);
        check({name, " oe"}, 64'(r_miso_oe_out), 64'd0);
        check({name, " busy"}, 64'(r_busy_out), 64'd0);
    endtask

    // Reference: what a mode-3 master sees on MISO for an n-clock frame.
    // Bits beyond the reply word read as 0.
    function automatic logic [63:0] exp_miso(input logic [SIZE-1:0] tx, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++)
            r = {r[62:0], (i < SIZE) ? tx[SIZE-1-i] : 1'b0};
        return r;
    endfunction

    // Mode-3 master. Bit i sent is mosi_bits[nbits-1-i]. lwc puts the last
    // SCK rise and the CS release on the same instant. rst_at_bit >= 0 pulses
    // reset before that bit, keeping CS low.
    task automatic spi_frame(input logic [63:0] mosi_bits, input int nbits, input int half,
                             input bit lwc, input int rst_at_bit,
                             output logic [63:0] miso_bits, output logic busy_mid);
        miso_bits = '0;
        cs_n_in = 1'b0;
        wait_clks(4);
        busy_mid = r_busy_out & r_miso_oe_out;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at_bit) begin
                reset_n_in = 1'b0;
                #1;
                check("rst miso", 64'(r_miso_out), 64'd0);
                check("rst oe", 64'(r_miso_oe_out), 64'd0);
                check("rst rx_data", 64'(r_rx_data_out), 64'd0);
                check("rst valid", 64'(r_valid_out), 64'd0);
                check("rst error", 64'(r_error_out), 64'd0);
                check("rst busy", 64'(r_busy_out), 64'd0);
                wait_clks(2);
                reset_n_in = 1'b1;
            end
            sck_in  = 1'b0;
            mosi_in = mosi_bits[nbits-1-i];
            wait_clks(half);
            miso_bits = {miso_bits[62:0], r_miso_out};
            if (lwc && i == nbits - 1) begin
                sck_in  = 1'b1;
                cs_n_in = 1'b1;
                return;
            end
            sck_in = 1'b1;
            wait_clks(half);
        end
        cs_n_in = 1'b1;
    endtask

    typedef struct {
        logic [SIZE-1:0] tx;
        logic [63:0]     mosi;
        int              nbits;
        int              half;
        bit              lwc;
        int              exp_valid;
        int              exp_error;
        logic [SIZE-1:0] exp_rx;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [63:0]     miso_w, miso_w2;
        logic            bm;
        int              v0, e0, lat;
        logic [SIZE-1:0] model_rx, tx1, tx2, m1, m2;

        vecs[0] = '{40'hA5_1234_5678, 64'h3C_DEAD_BEEF, 40, 8, 1'b0, 1, 0, 40'h3C_DEAD_BEEF};
        vecs[1] = '{40'h11_2233_4455, 64'h1ABCD,        17, 8, 1'b0, 0, 1, 40'h3C_DEAD_BEEF};
        vecs[2] = '{40'hFF_FFFF_FFFF, 64'h2AA_5555_AAAA, 42, 8, 1'b0, 0, 1, 40'h3C_DEAD_BEEF};
        vecs[3] = '{40'hC3_0F0F_F0F0, 64'h12_3456_789A, 40, 8, 1'b1, 0, 1, 40'h3C_DEAD_BEEF};
        vecs[4] = '{40'h80_0000_0000, 64'h00_0000_0001, 40, 4, 1'b0, 1, 0, 40'h00_0000_0001};
        vecs[5] = '{40'h5A_5A5A_5A5A, 64'h0,            0,  6, 1'b0, 0, 1, 40'h00_0000_0001};
        vecs[6] = '{40'h96_6996_6996, 64'h7F_FFFF_FFFF, 39, 5, 1'b0, 0, 1, 40'h00_0000_0001};

        // Reset state.
        #17;
        check("reset miso", 64'(r_miso_out), 64'd0);
        check("reset oe", 64'(r_miso_oe_out), 64'd0);
        check("reset rx_data", 64'(r_rx_data_out), 64'd0);
        check("reset valid", 64'(r_valid_out), 64'd0);
        check("reset error", 64'(r_error_out), 64'd0);
        check("reset busy", 64'(r_busy_out), 64'd0);
        wait_clks(1);
        reset_n_in = 1'b1;
        wait_clks(6);

        // Table-driven frames.
        for (int k = 0; k < 7; k++) begin
            tx_data_in = vecs[k].tx;
            v0 = valid_cnt;
            e0 = error_cnt;
            spi_frame(vecs[k].mosi, vecs[k].nbits, vecs[k].half, vecs[k].lwc, -1, miso_w, bm);
            wait_clks(12);
            check($sformatf("vec%0d busy_mid", k), 64'(bm), 64'd1);
            check($sformatf("vec%0d valid", k), 64'(valid_cnt - v0), 64'(vecs[k].exp_valid));
            check($sformatf("vec%0d error", k), 64'(error_cnt - e0), 64'(vecs[k].exp_error));
            check($sformatf("vec%0d rx_data", k), 64'(r_rx_data_out), 64'(vecs[k].exp_rx));
            check($sformatf("vec%0d master_rx", k), miso_w, exp_miso(vecs[k].tx, vecs[k].nbits));
            check_quiet($sformatf("vec%0d end", k));
        end

        // Latency from CS release to valid.
        tx_data_in = 40'h01_0203_0405;
        spi_frame(64'h0A_0B0C_0D0E, 40, 8, 1'b0, -1, miso_w, bm);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_in);
            #1;
            if (r_valid_out) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'(SYNC + 2));
        wait_clks(8);
        check("latency rx_data", 64'(r_rx_data_out), 64'h0A_0B0C_0D0E);

        // Reset mid-frame at bit 20, CS held low through the frame.
        tx_data_in = 40'hDE_ADBE_EF00;
        v0 = valid_cnt;
        e0 = error_cnt;
        spi_frame(64'hFF_00FF_00FF, 40, 8, 1'b0, 20, miso_w, bm);
        wait_clks(12);
        check("midrst valid", 64'(valid_cnt - v0), 64'd0);
        check("midrst error", 64'(error_cnt - e0), 64'd0);
        check("midrst rx_data", 64'(r_rx_data_out), 64'd0);
        check_quiet("midrst end");
        tx_data_in = 40'h24_6813_5790;
        spi_frame(64'h13_5724_680A, 40, 8, 1'b0, -1, miso_w, bm);
        wait_clks(12);
        check("postrst valid", 64'(valid_cnt - v0), 64'd1);
        check("postrst rx_data", 64'(r_rx_data_out), 64'h13_5724_680A);
        check("postrst master_rx", miso_w, exp_miso(40'h24_6813_5790, 40));

        // Back-to-back frames, SCK period 8, 4-cycle CS-high gap.
        tx1 = 40'hAB_CDEF_0123;
        tx2 = 40'h45_6789_ABCD;
        m1  = 40'h11_1111_1111;
        m2  = 40'hEE_EEEE_EEEE;
        rx_words.delete();
        v0 = valid_cnt;
        e0 = error_cnt;
        tx_data_in = tx1;
        spi_frame(64'(m1), 40, 4, 1'b0, -1, miso_w, bm);
        tx_data_in = tx2;
        wait_clks(4);
        spi_frame(64'(m2), 40, 4, 1'b0, -1, miso_w2, bm);
        wait_clks(12);
        check("b2b valid", 64'(valid_cnt - v0), 64'd2);
        check("b2b error", 64'(error_cnt - e0), 64'd0);
        check("b2b words", 64'(rx_words.size()), 64'd2);
        if (rx_words.size() == 2) begin
            check("b2b word0", 64'(rx_words[0]), 64'(m1));
            check("b2b word1", 64'(rx_words[1]), 64'(m2));
        end
        check("b2b master_rx0", miso_w, exp_miso(tx1, 40));
        check("b2b master_rx1", miso_w2, exp_miso(tx2, 40));
        model_rx = m2;

        // Randomized frames against the reference model; tx_data_in is
        // disturbed mid-frame and must not affect the reply.
        for (int k = 0; k < 20; k++) begin
            logic [SIZE-1:0] tx;
            logic [63:0]     mo;
            int              nb, hf, ev, ee;
            tx = {$urandom, $urandom};
            mo = {$urandom, $urandom};
            nb = ($urandom_range(0, 2) != 0) ? SIZE : int'($urandom_range(1, 44));
            hf = int'($urandom_range(4, 8));
            tx_data_in = tx;
            v0 = valid_cnt;
            e0 = error_cnt;
            fork
                spi_frame(mo, nb, hf, 1'b0, -1, miso_w, bm);
                begin
                    wait_clks(int'($urandom_range(10, 60)));
                    tx_data_in = {$urandom, $urandom};
                end
            join
            wait_clks(12);
            ev = (nb == SIZE) ? 1 : 0;
            ee = 1 - ev;
            if (ev == 1) model_rx = mo[SIZE-1:0];
            check($sformatf("rnd%0d valid", k), 64'(valid_cnt - v0), 64'(ev));
            check($sformatf("rnd%0d error", k), 64'(error_cnt - e0), 64'(ee));
            check($sformatf("rnd%0d rx_data", k), 64'(r_rx_data_out), 64'(model_rx));
            check($sformatf("rnd%0d master_rx", k), miso_w, exp_miso(tx, nb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
